// File: rtl/gcd_ci_pkg.sv
// Shared types and defaults for the GCD custom-instruction master.
package gcd_ci_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} gcd_mst_state_t;

    localparam int GCD_DATA_W      = 32;
    localparam int GCD_TIMEOUT_DEF = 4096;

endpackage

// File: rtl/ci_timeout_ctr.sv
// Cycle counter bounding how long the master waits for the slave's done pulse.
module ci_timeout_ctr #(
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int CW = $clog2(TIMEOUT_CYC) + 1;

    logic [CW-1:0] count;

    // Holds at terminal count so a stalled enable can never wrap back to zero.
    always_ff @(posedge clk) begin
        if (reset || clear)
            count <= '0;
        else if (enable && !tc)
            count <= count + 1'b1;
    end

    assign tc = (count == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/gcd_ci_master.sv
// Drives a multicycle GCD CI slave from a valid/ready request port and returns
// the result on a valid/ready response port, with zero-operand bypass and timeout.
module gcd_ci_master
    import gcd_ci_pkg::*;
#(
    parameter int DATA_W      = GCD_DATA_W,
    parameter int TIMEOUT_CYC = GCD_TIMEOUT_DEF
) (
    input  logic              csi_clk,
    input  logic              rsi_reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    output logic              ci_start,
    output logic [DATA_W-1:0] ci_dataa,
    output logic [DATA_W-1:0] ci_datab,
    input  logic              ci_done,
    input  logic [DATA_W-1:0] ci_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_timeout,
    output logic              rsp_bypass,
    output logic              busy
);

    gcd_mst_state_t state;
    logic           tc;

    ci_timeout_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
        .clk    (csi_clk),
        .reset  (rsi_reset),
        .clear  (state == ISSUE),
        .enable (state == WAIT),
        .tc     (tc)
    );

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_ff @(posedge csi_clk) begin
        if (rsi_reset) begin
            state       <= IDLE;
            ci_start    <= 1'b0;
            ci_dataa    <= '0;
            ci_datab    <= '0;
            rsp_valid   <= 1'b0;
            rsp_result  <= '0;
            rsp_timeout <= 1'b0;
            rsp_bypass  <= 1'b0;
        end else begin
            ci_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        rsp_timeout <= 1'b0;
                        rsp_bypass  <= 1'b0;
                        // A zero operand would keep the slave iterating forever.
                        if (req_a == '0 || req_b == '0) begin
                            rsp_result <= req_a | req_b;
                            rsp_bypass <= 1'b1;
                            rsp_valid  <= 1'b1;
                            state      <= RESP;
                        end else begin
                            ci_dataa <= req_a;
                            ci_datab <= req_b;
                            ci_start <= 1'b1;
                            state    <= ISSUE;
                        end
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    // A done arriving on the terminal-count cycle still counts.
                    if (ci_done) begin
                        rsp_result <= ci_result;
                        rsp_valid  <= 1'b1;
                        state      <= RESP;
                    end else if (tc) begin
                        rsp_result  <= '0;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
